// File: rtl/raizing_textvram_arbiter.sv
//==============================================================================
// Module      : raizing_textvram_arbiter
// Description : Shares one single-port text VRAM (1-cycle registered-read
//               BRAM) between the line text renderer and the 68k CPU bus.
//               The renderer has absolute priority and is never stalled. The
//               CPU is served in idle slots through a req/ack handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   CLK96, RESET96_N          : clock, synchronous active-low reset
//   REN_REQ/REN_ADDR          : renderer read strobe + address
//   REN_DATA/REN_VALID        : renderer read data + 1-cycle valid pulse
//   CPU_REQ/WE/BE/ADDR/DIN    : CPU access request (level, held until ACK)
//   CPU_DOUT/CPU_ACK          : CPU read data + 1-cycle completion pulse
//   CPU_STARVE                : CPU has waited WAIT_MAX cycles
//   CONFLICT_CNT              : conflict statistics (optional, see below)
//   RAM_ADDR/WE/BE/DIN        : registered VRAM command
//   RAM_DOUT                  : VRAM read data, 1 cycle after RAM_ADDR
// Configuration
//   RAIZING_TVRAM_STATS_EN    : when defined, adds CONFLICT_CNT[15:0], a
//                               saturating count of cycles in which the
//                               renderer blocked a pending CPU request.
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module raizing_textvram_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 16,
  parameter int WAIT_MAX = 64
) (
  input  logic          CLK96,
  input  logic          RESET96_N,
  input  logic          REN_REQ,
  input  logic [AW-1:0] REN_ADDR,
  output logic [DW-1:0] REN_DATA,
  output logic          REN_VALID,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [1:0]    CPU_BE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_DIN,
  output logic [DW-1:0] CPU_DOUT,
  output logic          CPU_ACK,
  output logic          CPU_STARVE,
`ifdef RAIZING_TVRAM_STATS_EN
  output logic [15:0]   CONFLICT_CNT,
`endif
  output logic [AW-1:0] RAM_ADDR,
  output logic          RAM_WE,
  output logic [1:0]    RAM_BE,
  output logic [DW-1:0] RAM_DIN,
  input  logic [DW-1:0] RAM_DOUT
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Owner of the data that RAM_DOUT will carry when this tag reaches stage 1.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_REN  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_e;

  state_e              state_q, state_d;
  tag_e                tag0_q, tag0_d;
  tag_e                tag1_q;
  logic [AW-1:0]       ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [1:0]          ram_be_q, ram_be_d;
  logic [DW-1:0]       ram_din_q, ram_din_d;
  logic [DW-1:0]       ren_hold_q, ren_hold_d;
  logic [DW-1:0]       cpu_hold_q, cpu_hold_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                ren_slot;
  logic                cpu_slot;
  logic                cpu_ret;

  // Renderer always wins; the CPU only gets a slot when the FSM is idle, which
  // also blocks re-sampling CPU_REQ during the ACK cycle.
  assign ren_slot = REN_REQ;
  assign cpu_slot = !REN_REQ && CPU_REQ && (state_q == S_IDLE);

  // A CPU read result is on RAM_DOUT in the cycle its tag sits in stage 1.
  assign cpu_ret  = (tag1_q == TAG_CPU);

  //--------------------------------------------------------------------------
  // CPU access FSM
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_slot) begin
          state_d = CPU_WE ? S_WR : S_RD;
        end
      end
      S_WR:    state_d = S_DONE;
      S_RD:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // Slot datapath, owner tags, wait counter
  //--------------------------------------------------------------------------
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    ram_be_d   = 2'b00;
    tag0_d     = TAG_NONE;
    if (ren_slot) begin
      ram_addr_d = REN_ADDR;
      tag0_d     = TAG_REN;
    end else if (cpu_slot) begin
      ram_addr_d = CPU_ADDR;
      if (CPU_WE) begin
        ram_we_d  = 1'b1;
        ram_be_d  = CPU_BE;
        ram_din_d = CPU_DIN;
      end else begin
        tag0_d    = TAG_CPU;
      end
    end
  end

  always_comb begin
    ren_hold_d = ren_hold_q;
    cpu_hold_d = cpu_hold_q;
    if (REN_VALID) begin
      ren_hold_d = RAM_DOUT;
    end
    if (cpu_ret) begin
      cpu_hold_d = RAM_DOUT;
    end
  end

  // The counter also ticks while the CPU's own access is in flight; ACK
  // clears it, so that only matters when it is already saturated.
  always_comb begin
    wait_d = wait_q;
    if (CPU_ACK) begin
      wait_d = '0;
    end else if (CPU_REQ && !cpu_slot && (wait_q != WAIT_W'(WAIT_MAX))) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      state_q    <= S_IDLE;
      tag0_q     <= TAG_NONE;
      tag1_q     <= TAG_NONE;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_be_q   <= 2'b00;
      ram_din_q  <= '0;
      ren_hold_q <= '0;
      cpu_hold_q <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      tag0_q     <= tag0_d;
      tag1_q     <= tag0_q;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_be_q   <= ram_be_d;
      ram_din_q  <= ram_din_d;
      ren_hold_q <= ren_hold_d;
      cpu_hold_q <= cpu_hold_d;
      wait_q     <= wait_d;
    end
  end

  //--------------------------------------------------------------------------
  // Outputs. Read data is taken straight from the BRAM output register in the
  // return cycle and held afterwards, so both requesters see a 2-cycle path.
  //--------------------------------------------------------------------------
  assign REN_VALID  = (tag1_q == TAG_REN);
  assign REN_DATA   = REN_VALID ? RAM_DOUT : ren_hold_q;
  assign CPU_ACK    = (state_q == S_DONE);
  assign CPU_DOUT   = cpu_ret ? RAM_DOUT : cpu_hold_q;
  assign CPU_STARVE = (wait_q == WAIT_W'(WAIT_MAX));
  assign RAM_ADDR   = ram_addr_q;
  assign RAM_WE     = ram_we_q;
  assign RAM_BE     = ram_be_q;
  assign RAM_DIN    = ram_din_q;

`ifdef RAIZING_TVRAM_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (REN_REQ && CPU_REQ && (state_q == S_IDLE) && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      conflict_q <= 16'd0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign CONFLICT_CNT = conflict_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_raizing_textvram_arbiter.sv
//==============================================================================
// Module      : tb_raizing_textvram_arbiter
// Description : Directed self-checking bench for raizing_textvram_arbiter,
//               with a behavioural byte-enabled 1-cycle-read BRAM model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_raizing_textvram_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ren_req;
  logic [AW-1:0] ren_addr;
  logic [DW-1:0] ren_data;
  logic          ren_valid;
  logic          cpu_req;
  logic          cpu_we;
  logic [1:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_ack;
  logic          cpu_starve;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [1:0]    ram_be;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
`ifdef RAIZING_TVRAM_STATS_EN
  logic [15:0]   conflict_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  raizing_textvram_arbiter #(.AW(AW), .DW(DW), .WAIT_MAX(64)) dut (
    .CLK96        (clk),
    .RESET96_N    (rst_n),
    .REN_REQ      (ren_req),
    .REN_ADDR     (ren_addr),
    .REN_DATA     (ren_data),
    .REN_VALID    (ren_valid),
    .CPU_REQ      (cpu_req),
    .CPU_WE       (cpu_we),
    .CPU_BE       (cpu_be),
    .CPU_ADDR     (cpu_addr),
    .CPU_DIN      (cpu_din),
    .CPU_DOUT     (cpu_dout),
    .CPU_ACK      (cpu_ack),
    .CPU_STARVE   (cpu_starve),
`ifdef RAIZING_TVRAM_STATS_EN
    .CONFLICT_CNT (conflict_cnt),
`endif
    .RAM_ADDR     (ram_addr),
    .RAM_WE       (ram_we),
    .RAM_BE       (ram_be),
    .RAM_DIN      (ram_din),
    .RAM_DOUT     (ram_dout)
  );

  // BRAM model: preloaded with addr ^ 16'hA5C3 while reset is low.
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < (1 << AW); i++) begin
        mem[i] <= 16'(i) ^ 16'hA5C3;
      end
    end else if (ram_we) begin
      if (ram_be[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
      if (ram_be[1]) mem[ram_addr][15:8] <= ram_din[15:8];
    end
    ram_dout <= mem[ram_addr];
  end

  // CPU access helper: starts and ends on a falling edge, drops REQ on ACK.
  task automatic cpu_access(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] din, input logic [1:0] be,
                            output logic [DW-1:0] dout, output int lat);
    lat  = -1;
    dout = '0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din; cpu_be = be;
    for (int i = 1; i <= 200 && lat < 0; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) begin
        lat  = i;
        dout = cpu_dout;
      end
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ren_req = 1'b0; ren_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 2'b00; cpu_addr = '0; cpu_din = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ren_valid, cpu_ack, cpu_starve, ram_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 0000", {ren_valid, cpu_ack, cpu_starve, ram_we});
    end
    n_tests++;
    if ({ren_data, cpu_dout, ram_din} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h exp 0", {ren_data, cpu_dout, ram_din});
    end
    n_tests++;
    if ({ram_addr, ram_be} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_ram_cmd got %h exp 0", {ram_addr, ram_be});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_renderer_burst();
    logic [DW-1:0] exp_d [0:7];
    logic          exp_v;
    exp_d[0] = 16'hA5D3; exp_d[1] = 16'hA5D2; exp_d[2] = 16'hA5D1; exp_d[3] = 16'hA5D0;
    exp_d[4] = 16'hA5D7; exp_d[5] = 16'hA5D6; exp_d[6] = 16'hA5D5; exp_d[7] = 16'hA5D4;
    for (int j = 0; j <= 10; j++) begin
      exp_v = (j >= 2 && j <= 9);
      n_tests++;
      if (ren_valid !== exp_v) begin
        n_fail++;
        $display("FAIL ren_valid[%0d] got %b exp %b", j, ren_valid, exp_v);
      end
      if (exp_v) begin
        n_tests++;
        if (ren_data !== exp_d[j-2]) begin
          n_fail++;
          $display("FAIL ren_data[%0d] got %h exp %h", j - 2, ren_data, exp_d[j-2]);
        end
      end
      if (j < 8) begin
        ren_req = 1'b1; ren_addr = 12'h010 + 12'(j);
      end else begin
        ren_req = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cpu_write_read();
    logic [DW-1:0] d;
    int            lat;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_din = 16'hBEEF; cpu_be = 2'b11;
    @(negedge clk);
    n_tests++;
    if ({ram_we, ram_be, ram_addr, ram_din, cpu_ack} !== {1'b1, 2'b11, 12'h123, 16'hBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_cmd got we=%b be=%b a=%h d=%h ack=%b exp we=1 be=11 a=123 d=beef ack=0",
               ram_we, ram_be, ram_addr, ram_din, cpu_ack);
    end
    @(negedge clk);
    n_tests++;
    if ({ram_we, cpu_ack} !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_ack got we=%b ack=%b exp we=0 ack=1", ram_we, cpu_ack);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cpu_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_ack_pulse got %b exp 0", cpu_ack);
    end
    cpu_access(1'b0, 12'h123, 16'h0000, 2'b00, d, lat);
    n_tests++;
    if (d !== 16'hBEEF || lat != 2) begin
      n_fail++;
      $display("FAIL rd_beef got %h lat %0d exp beef lat 2", d, lat);
    end
  endtask

  task automatic test_byte_enable();
    logic [DW-1:0] d;
    int            lat;
    cpu_access(1'b1, 12'h0A0, 16'h1234, 2'b11, d, lat);
    cpu_access(1'b1, 12'h0A0, 16'h00AA, 2'b01, d, lat);
    cpu_access(1'b0, 12'h0A0, 16'h0000, 2'b00, d, lat);
    n_tests++;
    if (d !== 16'h12AA) begin
      n_fail++;
      $display("FAIL be_low got %h exp 12aa", d);
    end
    cpu_access(1'b1, 12'h0A0, 16'hCD00, 2'b10, d, lat);
    cpu_access(1'b0, 12'h0A0, 16'h0000, 2'b00, d, lat);
    n_tests++;
    if (d !== 16'hCDAA) begin
      n_fail++;
      $display("FAIL be_high got %h exp cdaa", d);
    end
  endtask

  task automatic test_conflict_raw();
    // Renderer and CPU write collide; renderer first, then read-after-write.
    ren_req = 1'b1; ren_addr = 12'h123;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h0C0; cpu_din = 16'h7E57; cpu_be = 2'b11;
    @(negedge clk);
    n_tests++;
    if ({ram_we, ram_addr} !== {1'b0, 12'h123}) begin
      n_fail++;
      $display("FAIL conflict_ren_first got we=%b a=%h exp we=0 a=123", ram_we, ram_addr);
    end
    ren_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ram_we, ram_addr, ren_valid, ren_data} !== {1'b1, 12'h0C0, 1'b1, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL conflict_cpu_next got we=%b a=%h v=%b d=%h exp we=1 a=0c0 v=1 d=beef",
               ram_we, ram_addr, ren_valid, ren_data);
    end
    @(negedge clk);
    n_tests++;
    if (cpu_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_ack got %b exp 1", cpu_ack);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    ren_req = 1'b1; ren_addr = 12'h0C0;
    @(negedge clk);
    ren_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ren_valid, ren_data} !== {1'b1, 16'h7E57}) begin
      n_fail++;
      $display("FAIL raw_ren got v=%b d=%h exp v=1 d=7e57", ren_valid, ren_data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    // CPU read granted, renderer read granted the very next cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    @(negedge clk);
    ren_req = 1'b1; ren_addr = 12'h201;
    @(negedge clk);
    n_tests++;
    if ({cpu_ack, cpu_dout, ren_valid} !== {1'b1, 16'hA7C3, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_cpu got ack=%b d=%h rv=%b exp ack=1 d=a7c3 rv=0", cpu_ack, cpu_dout, ren_valid);
    end
    cpu_req = 1'b0; ren_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ren_valid, ren_data, cpu_ack, cpu_dout} !== {1'b1, 16'hA7C2, 1'b0, 16'hA7C3}) begin
      n_fail++;
      $display("FAIL b2b_ren got v=%b d=%h ack=%b cd=%h exp v=1 d=a7c2 ack=0 cd=a7c3",
               ren_valid, ren_data, cpu_ack, cpu_dout);
    end
    @(negedge clk);
  endtask

  task automatic test_starve();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h300;
    ren_req = 1'b1; ren_addr = 12'h050;
    for (int j = 1; j <= 70; j++) begin
      @(negedge clk);
      if (j == 63) begin
        n_tests++;
        if (cpu_starve !== 1'b0) begin
          n_fail++;
          $display("FAIL starve_63 got %b exp 0", cpu_starve);
        end
      end
      if (j == 64) begin
        n_tests++;
        if (cpu_starve !== 1'b1) begin
          n_fail++;
          $display("FAIL starve_64 got %b exp 1", cpu_starve);
        end
      end
    end
    ren_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cpu_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_ack_early got %b exp 0", cpu_ack);
    end
    @(negedge clk);
    n_tests++;
    if ({cpu_ack, cpu_dout, cpu_starve} !== {1'b1, 16'hA6C3, 1'b1}) begin
      n_fail++;
      $display("FAIL starve_ack got ack=%b d=%h st=%b exp ack=1 d=a6c3 st=1", cpu_ack, cpu_dout, cpu_starve);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({cpu_ack, cpu_starve} !== 2'b00) begin
      n_fail++;
      $display("FAIL starve_clear got ack=%b st=%b exp 00", cpu_ack, cpu_starve);
    end
`ifdef RAIZING_TVRAM_STATS_EN
    n_tests++;
    if (conflict_cnt !== 16'd71) begin
      n_fail++;
      $display("FAIL conflict_cnt got %0d exp 71", conflict_cnt);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
    @(negedge clk);
    rst_n = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({cpu_ack, ren_valid, ram_we, cpu_starve, ram_addr, cpu_dout, ren_data} !== 48'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got ack=%b rv=%b we=%b st=%b a=%h cd=%h rd=%h exp all 0",
               cpu_ack, ren_valid, ram_we, cpu_starve, ram_addr, cpu_dout, ren_data);
    end
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_tests++;
      if ({cpu_ack, ren_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL rstmid_no_ack[%0d] got ack=%b rv=%b exp 00", j, cpu_ack, ren_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_renderer_burst();
    test_cpu_write_read();
    test_byte_enable();
    test_conflict_raw();
    test_back_to_back();
    test_starve();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
